// File: rtl/r200_pkg.sv
// Shared definitions for the r200 front end: default datapath width, the fetch
// entry layout and the canonical NOP encoding.
package r200_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instrn;
  } fetch_entry_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTRN = 32'h0000_0013;

  function automatic fetch_entry_t make_entry(input logic [XLEN_DEFAULT-1:0] pc,
                                              input logic [XLEN_DEFAULT-1:0] instrn);
    fetch_entry_t e;
    e.pc     = pc;
    e.instrn = instrn;
    return e;
  endfunction

endpackage

// File: rtl/ifetch_queue_ptr.sv
// Wrapping circular-buffer pointer: increments modulo DEPTH and clears
// synchronously on reset or clr.
module ifq_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned AW = $clog2(DEPTH);

  // DEPTH is a power of two, so natural overflow provides the wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue between fetch and decode. Optional same-cycle
// pass-through of an empty queue is enabled with `define IFQ_BYPASS_EN.
module ifetch_queue
  import r200_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_instrn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instrn,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];

  logic [AW-1:0] rd;
  logic [AW-1:0] wr;

  logic empty;
  logic full;
  logic enq;
  logic deq;
  logic pass;
  logic store_enq;
  logic store_deq;

  always_comb begin
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    // A full queue still accepts when decode drains the head this cycle.
    in_ready = !flush && (!full || out_ready);
`ifdef IFQ_BYPASS_EN
    out_valid  = !flush && (!empty || in_valid);
    out_pc     = empty ? in_pc     : pc_mem[rd];
    out_instrn = empty ? in_instrn : ins_mem[rd];
    pass       = empty && in_valid && out_ready && !flush;
`else
    out_valid  = !flush && !empty;
    out_pc     = pc_mem[rd];
    out_instrn = ins_mem[rd];
    pass       = 1'b0;
`endif
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
    // A passed-through instruction touches neither storage nor pointers.
    store_enq = enq && !pass && !rst;
    store_deq = deq && !pass;
  end

  always_ff @(posedge clk) begin
    if (store_enq) begin
      pc_mem[wr]  <= in_pc;
      ins_mem[wr] <= in_instrn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({store_enq, store_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  ifq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (store_deq),
    .ptr (rd)
  );

  ifq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (store_enq),
    .ptr (wr)
  );

endmodule
